// File: rtl/priority_eval_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : priority_eval_sequencer
//  Purpose  : Per-scanline sequencer for the priority evaluator. For each pixel
//             it clears the datapath, runs BG_PASSES compare cycles, does two
//             palette RAM fetches and then hands the pixel downstream.
//             Optional macro PE_BLEND_SKIP_EN skips the second fetch when
//             blend_needed is low.
//  Revision : 1.0 - initial release
// ============================================================================
module priority_eval_sequencer #(
    parameter int LINE_WIDTH = 240,
    parameter int BG_PASSES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic       pram_ack,
    input  logic       blend_needed,
    input  logic       pix_ready,
    output logic [7:0] col,
    output logic       clear,
    output logic       send_address_1,
    output logic       send_address_2,
    output logic       read_data_1,
    output logic       read_data_2,
    output logic       pram_req,
    output logic       pix_valid,
    output logic       busy,
    output logic       line_done,
    output logic       overrun
);

    localparam int CNT_W = (BG_PASSES > 1) ? $clog2(BG_PASSES) : 1;
    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(BG_PASSES - 1);
    localparam logic [7:0]       LAST_COL  = 8'(LINE_WIDTH - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_ADDR1 = 3'd3;
    localparam logic [2:0] S_DATA1 = 3'd4;
    localparam logic [2:0] S_ADDR2 = 3'd5;
    localparam logic [2:0] S_DATA2 = 3'd6;
    localparam logic [2:0] S_EMIT  = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [7:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             line_done_q, line_done_d;
    logic             overrun_q, overrun_d;

`ifndef PE_BLEND_SKIP_EN
    logic w_unused_blend;
    assign w_unused_blend = blend_needed;
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        line_done_d = 1'b0;
        // Any request that arrives while a line is in flight is dropped.
        overrun_d   = line_start && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    state_d = S_CLEAR;
                    col_d   = 8'd0;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (cnt_q == EVAL_LAST) begin
                    state_d = S_ADDR1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ADDR1: begin
                if (pram_ack) begin
                    state_d = S_DATA1;
                end
            end
            S_DATA1: begin
`ifdef PE_BLEND_SKIP_EN
                state_d = blend_needed ? S_ADDR2 : S_EMIT;
`else
                state_d = S_ADDR2;
`endif
            end
            S_ADDR2: begin
                if (pram_ack) begin
                    state_d = S_DATA2;
                end
            end
            S_DATA2: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (pix_ready) begin
                    if (col_q == LAST_COL) begin
                        line_done_d = 1'b1;
                        col_d       = 8'd0;
                        state_d     = S_IDLE;
                    end else begin
                        col_d   = col_q + 8'd1;
                        state_d = S_CLEAR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                col_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            col_q       <= 8'd0;
            cnt_q       <= '0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Strobes decode from state alone, so reset forces them low immediately.
    always_comb begin
        clear          = 1'b0;
        send_address_1 = 1'b0;
        send_address_2 = 1'b0;
        read_data_1    = 1'b0;
        read_data_2    = 1'b0;
        pram_req       = 1'b0;
        pix_valid      = 1'b0;
        case (state_q)
            S_CLEAR: clear = 1'b1;
            S_ADDR1: begin
                send_address_1 = 1'b1;
                pram_req       = 1'b1;
            end
            S_DATA1: read_data_1 = 1'b1;
            S_ADDR2: begin
                send_address_2 = 1'b1;
                pram_req       = 1'b1;
            end
            S_DATA2: read_data_2 = 1'b1;
            S_EMIT:  pix_valid   = 1'b1;
            default: clear       = 1'b0;
        endcase
    end

    assign col       = col_q;
    assign busy      = (state_q != S_IDLE);
    assign line_done = line_done_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_priority_eval_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_priority_eval_sequencer
//  Purpose  : Self-checking bench: per-pixel step model plus directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_priority_eval_sequencer;

    localparam int LW = 240;
    localparam int BG = 4;
`ifdef PE_BLEND_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam int W_LD  = 0;
    localparam int W_SA1 = 1;
    localparam int W_SA2 = 2;
    localparam int W_HS  = 3;
    localparam int W_CLR = 4;
    localparam int W_COL = 5;

    logic       clk = 1'b0;
    logic       rst, line_start, pram_ack, blend_needed, pix_ready;
    logic [7:0] col;
    logic       clear, send_address_1, send_address_2, read_data_1, read_data_2;
    logic       pram_req, pix_valid, busy, line_done, overrun;

    priority_eval_sequencer #(.LINE_WIDTH(LW), .BG_PASSES(BG)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .pram_ack(pram_ack),
        .blend_needed(blend_needed), .pix_ready(pix_ready), .col(col),
        .clear(clear), .send_address_1(send_address_1), .send_address_2(send_address_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2), .pram_req(pram_req),
        .pix_valid(pix_valid), .busy(busy), .line_done(line_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model: a pixel is a fixed list of steps (0 clear, 1..BG eval, then
    // addr1, data1, addr2, data2, emit); ack/ready gate the wait steps.
    logic       m_busy, m_ld, m_ov;
    logic [7:0] m_col;
    int         m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_col <= 8'd0; m_k <= 0; m_ld <= 1'b0; m_ov <= 1'b0;
        end else begin
            m_ld <= 1'b0;
            m_ov <= line_start && m_busy;
            if (!m_busy) begin
                if (line_start) begin
                    m_busy <= 1'b1; m_col <= 8'd0; m_k <= 0;
                end
            end else if (m_k == BG + 1 || m_k == BG + 3) begin
                if (pram_ack) m_k <= m_k + 1;
            end else if (m_k == BG + 5) begin
                if (pix_ready) begin
                    m_k <= 0;
                    if (m_col == 8'(LW - 1)) begin
                        m_busy <= 1'b0; m_col <= 8'd0; m_ld <= 1'b1;
                    end else begin
                        m_col <= m_col + 8'd1;
                    end
                end
            end else if (m_k == BG + 2 && SKIP && !blend_needed) begin
                m_k <= BG + 5;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    function automatic logic [16:0] model_vec();
        logic c, s1, r1, s2, r2, pv;
        c  = m_busy && m_k == 0;
        s1 = m_busy && m_k == BG + 1;
        r1 = m_busy && m_k == BG + 2;
        s2 = m_busy && m_k == BG + 3;
        r2 = m_busy && m_k == BG + 4;
        pv = m_busy && m_k == BG + 5;
        return {m_col, c, s1, s2, r1, r2, s1 | s2, pv, m_busy, m_ld, m_ov};
    endfunction

    logic [16:0] dut_vec;
    assign dut_vec = {col, clear, send_address_1, send_address_2, read_data_1, read_data_2,
                      pram_req, pix_valid, busy, line_done, overrun};

    // Observed per-pixel / per-line statistics.
    int clear_cyc = 0, line_c0 = 0, a1_len = 0, a1_last = 0, r1_cyc = 0;
    int pv_len = 0, s2_cnt = 0, hs_count = 0, ld_count = 0, ov_count = 0;
    int line_done_cyc = 0, last_lat = 0, last_a1_len = 0, last_r1_gap = 0;
    int last_pv_len = 0, last_s2 = 0, last_col = 0, exp_hs_col = 0;

    initial forever begin
        @(negedge clk);
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL cycle_compare cyc=%0d actual=%h required=%h", cyc, dut_vec, model_vec());
        end
        if (rst) exp_hs_col = 0;
        if (clear) begin
            clear_cyc = cyc; a1_len = 0; pv_len = 0; s2_cnt = 0;
            if (col == 8'd0) line_c0 = cyc;
        end
        if (send_address_1) begin a1_len++; a1_last = cyc; end
        if (read_data_1) r1_cyc = cyc;
        if (send_address_2 || read_data_2) s2_cnt++;
        if (pix_valid) pv_len++;
        if (pix_valid && pix_ready) begin
            hs_count++;
            last_lat = cyc - clear_cyc + 1; last_a1_len = a1_len;
            last_r1_gap = r1_cyc - a1_last; last_pv_len = pv_len;
            last_s2 = s2_cnt; last_col = int'(col);
            chk("hs_col_order", int'(col), exp_hs_col);
            exp_hs_col = (exp_hs_col == LW - 1) ? 0 : exp_hs_col + 1;
        end
        if (line_done) begin ld_count++; line_done_cyc = cyc; end
        if (overrun) ov_count++;
    end

    task automatic wait_for(input int sel, input int val, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                W_LD:    hit = line_done;
                W_SA1:   hit = send_address_1;
                W_SA2:   hit = send_address_2;
                W_HS:    hit = pix_valid && pix_ready;
                W_CLR:   hit = clear;
                default: hit = (int'(col) == val);
            endcase
        end
        #1;
        if (!hit) begin
            checks++; failures++;
            $display("FAIL timeout_%s actual=none required=event", name);
        end
    endtask

    task automatic pulse_start();
        line_start = 1'b1;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    int hs0, ov0, ld0, col_before;

    initial begin
        rst = 1'b1; line_start = 1'b0; pram_ack = 1'b0; blend_needed = 1'b0; pix_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("reset_outputs", int'(dut_vec), 0);
        rst = 1'b0;

        // Full line, ack/ready tied high.
        pram_ack = 1'b1; pix_ready = 1'b1;
        hs0 = hs_count; ld0 = ld_count;
        pulse_start();
        wait_for(W_LD, 0, 2600, "line1");
        chk("line1_cycles", line_done_cyc - line_c0, 2400);
        chk("line1_pixels", hs_count - hs0, 240);
        chk("line1_last_col", last_col, 239);
        chk("line1_busy_after", int'(busy), 0);
        chk("line1_ld_pulses", ld_count - ld0, 1);

        // Delayed ack on the first fetch.
        pram_ack = 1'b0;
        pulse_start();
        wait_for(W_SA1, 0, 20, "sa1");
        repeat (3) @(posedge clk); #1;
        pram_ack = 1'b1;
        wait_for(W_HS, 0, 30, "hs_ack");
        chk("ack_addr1_len", last_a1_len, 4);
        chk("ack_rd1_gap", last_r1_gap, 1);
        chk("ack_latency", last_lat, 13);

        // Stalled downstream for 5 cycles in EMIT on pixel 1.
        wait_for(W_SA2, 0, 20, "sa2");
        col_before = int'(col);
        pix_ready = 1'b0;
        repeat (7) @(posedge clk); #1;
        pix_ready = 1'b1;
        wait_for(W_HS, 0, 20, "hs_stall");
        chk("stall_col", last_col, col_before);
        chk("stall_pv_len", last_pv_len, 6);
        chk("stall_latency", last_lat, 15);
        wait_for(W_CLR, 0, 5, "clr_after_stall");
        chk("stall_col_next", int'(col), col_before + 1);
        wait_for(W_LD, 0, 2600, "line2");

        // Overrun during a line.
        hs0 = hs_count; ov0 = ov_count;
        pulse_start();
        wait_for(W_COL, 17, 300, "col17");
        pulse_start();
        wait_for(W_LD, 0, 2600, "line3");
        chk("ovr_pulses", ov_count - ov0, 1);
        chk("ovr_line_cycles", line_done_cyc - line_c0, 2400);
        chk("ovr_line_pixels", hs_count - hs0, 240);

        // Next start is accepted; reset mid-fetch at col 100.
        pulse_start();
        wait_for(W_CLR, 0, 3, "restart_clear");
        chk("restart_busy", int'(busy), 1);
        wait_for(W_COL, 100, 1200, "col100");
        wait_for(W_SA2, 0, 20, "sa2_col100");
        rst = 1'b1;
        #1;
        chk("rst_outputs", int'(dut_vec), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_stays_idle", int'(busy), 0);

        // Blend-skip behaviour (both fetches when the feature is absent).
        blend_needed = 1'b0;
        pulse_start();
        wait_for(W_HS, 0, 20, "hs_noblend");
        chk("noblend_col", last_col, 0);
        chk("noblend_latency", last_lat, SKIP ? 8 : 10);
        chk("noblend_fetch2", last_s2, SKIP ? 0 : 2);
        blend_needed = 1'b1;
        wait_for(W_HS, 0, 20, "hs_blend");
        chk("blend_col", last_col, 1);
        chk("blend_latency", last_lat, 10);
        chk("blend_fetch2", last_s2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
